// File: rtl/ahb_lite_master_ctrl.sv
// Single-master AHB-Lite transfer controller: takes one SINGLE/INCR4 command at a time
// and sequences the pipelined address/data phases, wait states and two-cycle ERROR response.
module ahb_lite_master_ctrl #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic              req_incr4,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              wdata_pop,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              err,
  output logic              hsel,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [3:0]        hprot,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_DATA_LAST = 3'd2,
    S_ERR1      = 3'd3,
    S_ERR2      = 3'd4,
    S_REJECT    = 3'd5
  } state_t;

  localparam logic [1:0]        HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]        HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0]        HTRANS_SEQ    = 2'b11;
  localparam logic [2:0]        HBURST_SINGLE = 3'b000;
  localparam logic [2:0]        HBURST_INCR4  = 3'b011;
  localparam logic [2:0]        MAX_SIZE      = 3'($clog2(DATA_W / 8));
  localparam logic [ADDR_W-1:0] ONE_A         = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_htrans;
  logic                r_hsel;
  logic [ADDR_W-1:0]   r_haddr;
  logic                r_hwrite;
  logic [2:0]          r_hsize;
  logic [2:0]          r_hburst;
  logic [3:0]          r_hprot;
  logic [DATA_W-1:0]   r_hwdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rdata_valid;
  logic                r_done;
  logic                r_err;
  logic [1:0]          r_beat;
  logic [1:0]          r_last_beat;
  logic                r_dp_valid;

  logic                w_accept;
  logic                w_done_nxt;
  logic                w_err_nxt;
  logic                w_size_bad;
  logic                w_misalign;
  logic                w_cross_1k;
  logic                w_illegal;
  logic                w_dp_err;
  logic                w_dp_ok;
  logic [ADDR_W-1:0]   w_align_mask;
  logic [ADDR_W-1:0]   w_addr_incr;
  logic [11:0]         w_burst_end;

  // Command legality: size within the bus, natural alignment, INCR4 stays inside one 1KB page
  assign w_size_bad   = (req_size > MAX_SIZE);
  assign w_align_mask = (ONE_A << req_size) - ONE_A;
  assign w_misalign   = |(req_addr & w_align_mask);
  assign w_burst_end  = {2'b00, req_addr[9:0]} + (12'd4 << req_size);
  assign w_cross_1k   = req_incr4 & (w_burst_end > 12'd1024);
  assign w_illegal    = w_size_bad | w_misalign | w_cross_1k;

  assign w_dp_err    = r_dp_valid & hresp & ~hready;
  assign w_dp_ok     = r_dp_valid & hready & ~hresp;
  assign w_addr_incr = ONE_A << r_hsize;

  assign req_ready   = (r_state == S_IDLE) | (r_state == S_REJECT);
  assign wdata_pop   = (r_state == S_ADDR) & r_hwrite & hready;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign done        = r_done;
  assign err         = r_err;
  assign hsel        = r_hsel;
  assign haddr       = r_haddr;
  assign htrans      = r_htrans;
  assign hwrite      = r_hwrite;
  assign hsize       = r_hsize;
  assign hburst      = r_hburst;
  assign hprot       = r_hprot;
  assign hwdata      = r_hwdata;

  // State register
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and completion flags
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      // REJECT is the cycle its done pulse is visible, so it accepts like IDLE
      S_IDLE, S_REJECT: begin
        if (req_valid) begin
          if (w_illegal) begin
            w_state_nxt = S_REJECT;
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_ADDR;
            w_accept    = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ADDR: begin
        if (w_dp_err) begin
          w_state_nxt = S_ERR1;
        end else if (hready && (r_beat == r_last_beat)) begin
          w_state_nxt = S_DATA_LAST;
        end else begin
          w_state_nxt = S_ADDR;
        end
      end
      S_DATA_LAST: begin
        if (w_dp_err) begin
          w_state_nxt = S_ERR1;
        end else if (hready) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_DATA_LAST;
        end
      end
      // ERR2 only exists if the slave stretches the second error cycle
      S_ERR1, S_ERR2: begin
        if (hready) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
        end else begin
          w_state_nxt = S_ERR2;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // AHB address/control, write data, read capture and completion pulses
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_htrans      <= HTRANS_IDLE;
      r_hsel        <= 1'b0;
      r_haddr       <= {ADDR_W{1'b0}};
      r_hwrite      <= 1'b0;
      r_hsize       <= 3'd0;
      r_hburst      <= 3'd0;
      r_hprot       <= 4'd0;
      r_hwdata      <= {DATA_W{1'b0}};
      r_rdata       <= {DATA_W{1'b0}};
      r_rdata_valid <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_beat        <= 2'd0;
      r_last_beat   <= 2'd0;
      r_dp_valid    <= 1'b0;
    end else begin
      r_done        <= w_done_nxt;
      r_err         <= w_err_nxt;
      r_rdata_valid <= 1'b0;
      if (w_dp_ok && !r_hwrite) begin
        r_rdata       <= hrdata;
        r_rdata_valid <= 1'b1;
      end
      if (w_accept) begin
        r_htrans    <= HTRANS_NONSEQ;
        r_hsel      <= 1'b1;
        r_haddr     <= req_addr;
        r_hwrite    <= req_write;
        r_hsize     <= req_size;
        r_hburst    <= req_incr4 ? HBURST_INCR4 : HBURST_SINGLE;
        r_hprot     <= HPROT_VAL;
        r_beat      <= 2'd0;
        r_last_beat <= req_incr4 ? 2'd3 : 2'd0;
        r_dp_valid  <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR: begin
            if (w_dp_err) begin
              // Cancel the pending address phase during the second error cycle
              r_htrans   <= HTRANS_IDLE;
              r_hsel     <= 1'b0;
              r_dp_valid <= 1'b0;
            end else if (hready) begin
              r_dp_valid <= 1'b1;
              if (r_hwrite) begin
                r_hwdata <= req_wdata;
              end
              if (r_beat == r_last_beat) begin
                r_htrans <= HTRANS_IDLE;
                r_hsel   <= 1'b0;
              end else begin
                r_htrans <= HTRANS_SEQ;
                r_haddr  <= r_haddr + w_addr_incr;
                r_beat   <= r_beat + 2'd1;
              end
            end
          end
          S_DATA_LAST: begin
            if (w_dp_err || hready) begin
              r_dp_valid <= 1'b0;
            end
          end
          default: begin
            r_dp_valid <= r_dp_valid;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master_ctrl.sv
// Self-checking bench for ahb_lite_master_ctrl: an in-bench AHB slave applies wait states and
// ERROR responses; expectations come from a beat/latency model computed per command.
module tb_ahb_lite_master_ctrl;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [2:0]  req_size = 3'd0;
  logic        req_incr4 = 1'b0;
  logic [31:0] req_wdata = 32'd0;
  logic        wdata_pop;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        done;
  logic        err;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata = 32'd0;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;

  int n_vec = 0;
  int n_mis = 0;

  always #5 hclk = ~hclk;

  ahb_lite_master_ctrl #(.ADDR_W(32), .DATA_W(32), .HPROT_VAL(4'b0011)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_incr4(req_incr4),
    .req_wdata(req_wdata), .wdata_pop(wdata_pop),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .err(err),
    .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One command: stalls holds 2 bits of wait states per beat, err_beat<0 means no ERROR.
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic incr4, input logic [7:0] stalls, input int err_beat,
                         input bit fixed);
    logic [31:0] wv[4];
    logic [31:0] rv[4];
    int sb[4];
    int nb, bytes, e, exp_done, exp_naddr, exp_nrd, exp_pops;
    bit illegal, exp_err;
    int cyc, naddr, nrd, pops, done_cyc, dp_beat, dp_wait, err_stage;
    bit done_err, dp_active, pop_pend, traffic, held;
    logic [31:0] held_addr;

    nb    = incr4 ? 4 : 1;
    bytes = 1 << size;
    for (int i = 0; i < 4; i++) begin
      sb[i] = int'((stalls >> (2 * i)) & 8'd3);
      wv[i] = fixed ? (32'hDEADBEEF + 32'(i)) : $urandom;
      rv[i] = fixed ? 32'(i + 1) : $urandom;
    end
    illegal = (size > 3'd2) || ((addr % bytes) != 0) ||
              (incr4 && (int'(addr % 1024) + 4 * bytes > 1024));
    e = (err_beat >= 0 && err_beat < nb) ? err_beat : -1;
    if (illegal) begin
      exp_done = 1; exp_err = 1'b1; exp_naddr = 0; exp_nrd = 0;
    end else if (e >= 0) begin
      exp_done = 2 + sb[e] + 2;
      for (int b = 0; b < e; b++) exp_done += 1 + sb[b];
      exp_err = 1'b1; exp_naddr = e + 1; exp_nrd = wr ? 0 : e;
    end else begin
      exp_done = 2;
      for (int b = 0; b < nb; b++) exp_done += 1 + sb[b];
      exp_err = 1'b0; exp_naddr = nb; exp_nrd = wr ? 0 : nb;
    end
    exp_pops = wr ? exp_naddr : 0;

    @(negedge hclk);
    chk("ready_before", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size;
    req_incr4 = incr4; req_wdata = wv[0];
    cyc = 0; naddr = 0; nrd = 0; pops = 0; done_cyc = -1; done_err = 1'b0;
    dp_active = 1'b0; dp_beat = 0; dp_wait = 0; err_stage = 0;
    pop_pend = 1'b0; traffic = 1'b0; held = 1'b0; held_addr = 32'd0;

    while (done_cyc < 0 && cyc < 60) begin
      @(negedge hclk);
      cyc++;
      req_valid = 1'b0;
      if (pop_pend) begin
        req_wdata = wv[(pops < 4) ? pops : 3];
        pop_pend  = 1'b0;
      end
      hready = 1'b1; hresp = 1'b0; hrdata = $urandom;
      if (dp_active) begin
        if (dp_wait > 0) begin
          hready = 1'b0; dp_wait--;
        end else if (err_stage == 0 && dp_beat == e) begin
          hready = 1'b0; hresp = 1'b1; err_stage = 1;
        end else if (err_stage == 1) begin
          hresp = 1'b1; err_stage = 2;
        end else begin
          hrdata = rv[dp_beat];
        end
      end
      #1;
      if (rdata_valid) begin
        if (nrd < 4) chk("rdata", {32'd0, rdata}, {32'd0, rv[nrd]});
        nrd++;
      end
      if (done) begin
        done_cyc = cyc; done_err = err;
        chk("ready_at_done", {63'd0, req_ready}, 64'd1);
      end
      if (htrans != 2'b00) traffic = 1'b1;
      if (err_stage == 2 && hresp && hready) begin
        chk("htrans_cancel", {62'd0, htrans}, 64'd0);
      end
      if (dp_active && wr) chk("hwdata", {32'd0, hwdata}, {32'd0, wv[dp_beat]});
      if (dp_active && hready) dp_active = 1'b0;
      if (htrans != 2'b00) begin
        if (held) chk("addr_hold", {32'd0, haddr}, {32'd0, held_addr});
        held = !hready; held_addr = haddr;
        if (hready) begin
          chk("haddr", {32'd0, haddr}, 64'(addr + 32'(naddr * bytes)));
          chk("htrans", {62'd0, htrans}, (naddr == 0) ? 64'd2 : 64'd3);
          chk("hctl", {52'd0, hsel, hwrite, hsize, hburst, hprot},
              {52'd0, 1'b1, wr, size, (incr4 ? 3'b011 : 3'b000), 4'b0011});
          dp_active = 1'b1; dp_beat = (naddr < 4) ? naddr : 3;
          dp_wait = sb[dp_beat]; err_stage = 0;
          naddr++;
        end
      end
      if (wdata_pop) begin
        pops++; pop_pend = 1'b1;
      end
    end

    chk("done_lat", 64'(done_cyc), 64'(exp_done));
    chk("done_err", {63'd0, done_err}, {63'd0, exp_err});
    chk("n_addr", 64'(naddr), 64'(exp_naddr));
    chk("n_rdata", 64'(nrd), 64'(exp_nrd));
    chk("n_pop", 64'(pops), 64'(exp_pops));
    if (illegal) chk("reject_no_traffic", {63'd0, traffic}, 64'd0);
    hready = 1'b1; hresp = 1'b0;
    @(negedge hclk); #1;
    chk("done_pulse", {63'd0, done}, 64'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    logic        inc;
    int          eb;

    repeat (3) @(negedge hclk);
    #1;
    chk("rst_ahb", {hsel, hwrite, htrans, hsize, hburst, hprot, haddr, hwdata},
        {1'b0, 1'b0, 2'b00, 3'd0, 3'd0, 4'd0, 32'd0, 32'd0});
    chk("rst_flags", {60'd0, rdata_valid, wdata_pop, done, err}, 64'd0);
    chk("rst_rdata", {32'd0, rdata}, 64'd0);
    hresetn = 1'b1;
    @(negedge hclk); #1;
    chk("ready_after_rst", {63'd0, req_ready}, 64'd1);

    run_cmd(1'b1, 32'h100, 3'd2, 1'b0, 8'h00, -1, 1'b1);
    run_cmd(1'b0, 32'h20,  3'd2, 1'b1, 8'h00, -1, 1'b1);
    run_cmd(1'b1, 32'h40,  3'd2, 1'b1, 8'h08, -1, 1'b1);
    run_cmd(1'b0, 32'h80,  3'd2, 1'b1, 8'h00, 1,  1'b1);
    run_cmd(1'b0, 32'h3FC, 3'd2, 1'b1, 8'h00, -1, 1'b1);
    run_cmd(1'b1, 32'h102, 3'd2, 1'b0, 8'h00, -1, 1'b1);
    run_cmd(1'b0, 32'h0,   3'd3, 1'b0, 8'h00, -1, 1'b1);
    run_cmd(1'b1, 32'h3F0, 3'd2, 1'b1, 8'h00, -1, 1'b0);
    run_cmd(1'b1, 32'h10,  3'd1, 1'b1, 8'h55, 3,  1'b0);

    // Reset asserted while beat 2 of an INCR4 read is in its address phase
    @(negedge hclk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20; req_size = 3'd2; req_incr4 = 1'b1;
    hready = 1'b1; hresp = 1'b0; hrdata = 32'h5A5A0001;
    @(negedge hclk); req_valid = 1'b0;
    @(negedge hclk);
    @(negedge hclk); #1;
    chk("rst_pre_addr", {32'd0, haddr}, 64'h28);
    chk("rst_pre_rv", {63'd0, rdata_valid}, 64'd1);
    hresetn = 1'b0; #1;
    chk("rst_mid_ahb", {hsel, htrans, haddr, hburst, hprot}, {1'b0, 2'b00, 32'd0, 3'd0, 4'd0});
    chk("rst_mid_out", {rdata_valid, done, err, wdata_pop, rdata}, {4'b0000, 32'd0});
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge hclk); #1;
      chk("rst_no_done", {61'd0, done, htrans}, 64'd0);
    end
    run_cmd(1'b0, 32'h20, 3'd2, 1'b1, 8'h00, -1, 1'b1);

    for (int n = 0; n < 40; n++) begin
      sz  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      inc = 1'($urandom_range(0, 1));
      a   = 32'($urandom_range(0, 4095)) & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 5) == 0) a = 32'h400 - (32'd1 << sz) * 32'($urandom_range(1, 4));
      if ($urandom_range(0, 9) == 0) a = a | 32'd1;
      eb  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : -1;
      run_cmd(1'($urandom_range(0, 1)), a, sz, inc, 8'($urandom_range(0, 255)), eb, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
